reg_access_arbiter: RTL
=======================

# reg_access_arbiter

Two-port round-robin arbiter and sequencer for the shared 8-bit main register. It turns requester read/write transactions into correctly timed active-low strobes on the register's write-enable (EWR) and output-enable (EDY) pins. It sits between two datapath clients and the register instance, and returns read data and completion pulses to the requesters.

## Interface
- NUMBITS, 8, data width of the register and all data ports
- CLOCK  input  1  system clock; all state changes on rising edge
- RESET  input  1  synchronous, active-high reset
- REQ0, REQ1  input  1  transaction request per requester; held high until matching DONE
- WE0, WE1  input  1  1 = write, 0 = read; sampled with REQ at grant
- WDATA0, WDATA1  input  NUMBITS  write data; sampled at grant
- GNT0, GNT1  output  1  high from grant cycle through DONE cycle of the owning requester
- DONE0, DONE1  output  1  one-cycle completion pulse
- RDATA  output  NUMBITS  read result; valid in DONE cycle of a read, held until next read completes
- REG_DATA  output  NUMBITS  data driven to register DATA pins
- REG_EWR  output  1  register write strobe, active low
- REG_EDY  output  1  register output enable, active low
- REG_Q  input  NUMBITS  register OUTRESULT

## Operation
- States: IDLE, WRITE, READ, SAMPLE, DONE. All outputs are registered.
- Reset values: state IDLE, GNT0/1=0, DONE0/1=0, RDATA=0, REG_DATA=0, REG_EWR=1, REG_EDY=1, priority pointer = requester 0.
- IDLE arbitration:
  - Only REQ0 high -> grant 0.
  - Only REQ1 high -> grant 1.
  - Both high -> grant the requester not served last. The pointer is updated at each grant.
  - On grant, latch WE and WDATA of the winner, and set its GNT.
- WRITE (1 cycle): REG_EWR=0, REG_DATA=latched data. Next state DONE.
- READ (1 cycle): REG_EDY=0. Next state SAMPLE.
- SAMPLE (1 cycle): REG_EDY stays 0; RDATA <= REG_Q at end of cycle. Next state DONE.
- DONE (1 cycle): DONEx=1 for the owner, GNTx still 1, REG_EWR=REG_EDY=1. Next state IDLE; GNT drops.
- REQ is not re-sampled in DONE. At least one IDLE cycle separates transactions.
- A REQ dropping mid-transaction is ignored; the transaction completes and DONE still pulses.
- A new REQ from the non-owner during a transaction waits; it is arbitrated in the next IDLE.
- The non-owner's WE/WDATA changes are ignored throughout.
- REG_EWR and REG_EDY are never low in the same cycle. Only one GNT is high at a time.
- RESET while busy: the next edge forces reset values. No DONE is issued for the aborted transaction, and the pointer returns to requester 0.
- The write path never inverts data. Inversion is handled inside the register.

## Timing
- Write: REQ seen at edge n -> GNT and REG_EWR=0 in cycle n+1 -> DONE in cycle n+2 -> IDLE in cycle n+3.
- Read: REQ seen at edge n -> GNT and REG_EDY=0 in n+1 and n+2 -> RDATA valid and DONE in n+3.
- Back-to-back requests from the same requester: REQ held high through DONE gives a new grant at the earliest in n+4 (write) or n+5 (read).
- Worst-case wait for a pending requester: one full read of the other port plus one IDLE cycle = 5 cycles.
- RDATA and REG_DATA change only on rising CLOCK edges.

## Test plan
- Reset: hold RESET 2 cycles -> all outputs at reset values, REG_EWR=REG_EDY=1, GNT0=GNT1=0.
- Single write, then read: REQ0=1, WE0=1, WDATA0=8'hA5.
  - Write: REG_EWR=0 exactly one cycle with REG_DATA=8'hA5, then DONE0 one cycle later.
  - Read: REQ0 with WE0=0 and REG_Q model returning 8'hA5 -> REG_EDY=0 for 2 cycles, RDATA=8'hA5 with DONE0 in cycle n+3.
- Contention: REQ0 and REQ1 both high from reset.
  - Order is grant 0, grant 1, grant 0, grant 1 across four writes (8'h01, 8'h02 alternating).
  - GNT0 and GNT1 never high together.
- Late request: REQ1 rises in the WRITE cycle of requester 0 -> GNT1 no earlier than the cycle after DONE0's following IDLE. WDATA1 is sampled then, not earlier.
- Abort: RESET asserted in the SAMPLE cycle of a read -> next cycle REG_EDY=1, GNT=0, RDATA=0, no DONE pulse. A subsequent REQ1-only request is granted normally.
- REQ drop: REQ0 deasserted during WRITE -> REG_EWR pulse still completes and DONE0 still pulses once.

Source files
------------

// File: rtl/reg_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : reg_access_arbiter
// Brief    : Two-port round-robin arbiter/sequencer for the shared main register
// Revision : 1.0 - initial release
// ============================================================================
module reg_access_arbiter #(
    parameter int NUMBITS = 8
) (
    input  logic               CLOCK,
    input  logic               RESET,
    input  logic               REQ0,
    input  logic               REQ1,
    input  logic               WE0,
    input  logic               WE1,
    input  logic [NUMBITS-1:0] WDATA0,
    input  logic [NUMBITS-1:0] WDATA1,
    output logic               GNT0,
    output logic               GNT1,
    output logic               DONE0,
    output logic               DONE1,
    output logic [NUMBITS-1:0] RDATA,
    output logic [NUMBITS-1:0] REG_DATA,
    output logic               REG_EWR,
    output logic               REG_EDY,
    input  logic [NUMBITS-1:0] REG_Q
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WRITE  = 3'd1,
        S_READ   = 3'd2,
        S_SAMPLE = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t               r_state, w_state;
    logic                 r_owner, w_owner;
    logic                 r_prio,  w_prio;
    logic                 r_gnt0,  w_gnt0;
    logic                 r_gnt1,  w_gnt1;
    logic                 r_done0, w_done0;
    logic                 r_done1, w_done1;
    logic                 r_ewr,   w_ewr;
    logic                 r_edy,   w_edy;
    logic [NUMBITS-1:0]   r_rdata, w_rdata;
    logic [NUMBITS-1:0]   r_wdata, w_wdata;
    logic                 w_any;
    logic                 w_win;

    // r_prio names the requester that wins a tie; it flips to the loser on every grant.
    always_comb begin
        w_any = REQ0 | REQ1;
        w_win = 1'b0;
        if (REQ1 && (!REQ0 || r_prio)) begin
            w_win = 1'b1;
        end
    end

    always_comb begin
        w_state = r_state;
        w_owner = r_owner;
        w_prio  = r_prio;
        w_gnt0  = r_gnt0;
        w_gnt1  = r_gnt1;
        w_done0 = 1'b0;
        w_done1 = 1'b0;
        w_ewr   = 1'b1;
        w_edy   = 1'b1;
        w_rdata = r_rdata;
        w_wdata = r_wdata;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_owner = w_win;
                    w_prio  = ~w_win;
                    w_gnt0  = ~w_win;
                    w_gnt1  = w_win;
                    if (w_win ? WE1 : WE0) begin
                        w_state = S_WRITE;
                        w_ewr   = 1'b0;
                        w_wdata = w_win ? WDATA1 : WDATA0;
                    end else begin
                        w_state = S_READ;
                        w_edy   = 1'b0;
                    end
                end
            end
            S_WRITE: begin
                w_state = S_DONE;
                w_done0 = ~r_owner;
                w_done1 = r_owner;
            end
            S_READ: begin
                w_state = S_SAMPLE;
                w_edy   = 1'b0;
            end
            S_SAMPLE: begin
                w_state = S_DONE;
                w_rdata = REG_Q;
                w_done0 = ~r_owner;
                w_done1 = r_owner;
            end
            S_DONE: begin
                w_state = S_IDLE;
                w_gnt0  = 1'b0;
                w_gnt1  = 1'b0;
            end
            default: begin
                w_state = S_IDLE;
                w_gnt0  = 1'b0;
                w_gnt1  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_state <= S_IDLE;
            r_owner <= 1'b0;
            r_prio  <= 1'b0;
            r_gnt0  <= 1'b0;
            r_gnt1  <= 1'b0;
            r_done0 <= 1'b0;
            r_done1 <= 1'b0;
            r_ewr   <= 1'b1;
            r_edy   <= 1'b1;
            r_rdata <= '0;
            r_wdata <= '0;
        end else begin
            r_state <= w_state;
            r_owner <= w_owner;
            r_prio  <= w_prio;
            r_gnt0  <= w_gnt0;
            r_gnt1  <= w_gnt1;
            r_done0 <= w_done0;
            r_done1 <= w_done1;
            r_ewr   <= w_ewr;
            r_edy   <= w_edy;
            r_rdata <= w_rdata;
            r_wdata <= w_wdata;
        end
    end

    assign GNT0     = r_gnt0;
    assign GNT1     = r_gnt1;
    assign DONE0    = r_done0;
    assign DONE1    = r_done1;
    assign RDATA    = r_rdata;
    assign REG_DATA = r_wdata;
    assign REG_EWR  = r_ewr;
    assign REG_EDY  = r_edy;

endmodule
`default_nettype wire
